// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the line-memory responder.
// Holds the FSM encoding, line geometry and the index-width helper.
package dmem_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Floor of 1 keeps the index slice legal for a single-line array.
  function automatic int idx_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_responder.sv
// Line-memory responder: one request at a time, ack LATENCY cycles after acceptance.
// Initiator holds enable until ack; the DONE state waits for enable to drop before re-arming.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W = idx_width(DEPTH);

  logic [LINE_W-1:0] mem [DEPTH];

  state_t            state;
  logic [7:0]        cnt;
  logic              wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdat_q;
  logic              commit;

  // Offset bits and index bits above the array size are dropped, so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  assign commit = (state == ST_BUSY) && (cnt == 8'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      ack_o  <= 1'b0;
      data_o <= '0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      wdat_q <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            wr_q   <= write_i;
            idx_q  <= addr_i[OFFSET_W +: IDX_W];
            wdat_q <= data_i;
            cnt    <= 8'(LATENCY - 1);
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 8'd0) begin
            state <= ST_ACK;
            ack_o <= 1'b1;
            if (!wr_q) data_o <= mem[idx_q];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_ACK:  state <= ST_DONE;
        ST_DONE: if (!enable_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage is never reset; reset forces IDLE asynchronously, which cancels a pending commit.
  always_ff @(posedge clk_i) begin
    if (commit && wr_q) mem[idx_q] <= wdat_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a line-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 512;
  localparam int LAT   = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [LINE_W-1:0] ref_mem [DEPTH];
  bit                ref_vld [DEPTH];
  logic [LINE_W-1:0] last_rd;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full handshake; inputs are scrambled after acceptance to prove they are latched.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [LINE_W-1:0] d,
                        input string tag, input int hold);
    int n;
    int acks;
    int idx;
    idx      = line_of(a);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    tick();
    write_i = 1'($urandom);
    addr_i  = $urandom;
    data_i  = rand_line();
    n = 0;
    while (ack_o !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, LINE_W'(n), LINE_W'(LAT));
    if (w) begin
      check({tag, "_dout_kept"}, data_o, last_rd);
      ref_mem[idx] = d;
      ref_vld[idx] = 1'b1;
    end else begin
      check({tag, "_rdata"}, data_o, ref_mem[idx]);
      last_rd = ref_mem[idx];
    end
    acks = 0;
    repeat (hold) begin
      tick();
      acks += int'(ack_o);
    end
    enable_i = 1'b0;
    tick();
    acks += int'(ack_o);
    tick();
    acks += int'(ack_o);
    check({tag, "_single_ack"}, LINE_W'(acks), '0);
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    logic [LINE_W-1:0] p7;
    logic [31:0]       a;
    logic              w;
    int                acks;

    last_rd = '0;

    // Reset held with enable asserted must not start a request.
    rst_i    = 1'b0;
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0;
    data_i   = '1;
    repeat (3) tick();
    check("rst_ack", LINE_W'(ack_o), '0);
    check("rst_dout", data_o, '0);
    enable_i = 1'b0;
    rst_i    = 1'b1;
    acks = 0;
    repeat (15) begin
      tick();
      acks += int'(ack_o);
    end
    check("idle_no_ack", LINE_W'(acks), '0);

    // Read latency and data for line 3.
    do_req(1'b1, 32'h0000_0060, {32{8'hA5}}, "pre3", 0);
    do_req(1'b0, 32'h0000_0060, '0, "rd3", 0);
    check("rd3_pattern", data_o, {32{8'hA5}});

    // Write then read; data_o must hold the previous read across the write ack.
    d = {8{32'h1234_5678}};
    do_req(1'b1, 32'h0000_0400, d, "wr400", 0);
    do_req(1'b0, 32'h0000_0400, '0, "rd400", 0);
    check("rd400_pattern", data_o, d);

    // Enable held after ack gives one ack; re-raising gives a second.
    do_req(1'b0, 32'h0000_0060, '0, "held", 5);
    do_req(1'b0, 32'h0000_0060, '0, "reacc", 0);

    // Index 513 wraps to line 1; offset bits are ignored.
    d = rand_line();
    do_req(1'b1, 32'h0000_4020, d, "wrap_wr", 0);
    do_req(1'b0, 32'h0000_003F, '0, "wrap_rd", 0);
    check("wrap_pattern", data_o, d);

    // Reset four cycles into a write to line 7 discards it.
    p7 = rand_line();
    do_req(1'b1, 32'h0000_00E0, p7, "pre7", 0);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_00E0;
    data_i   = ~p7;
    tick();
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    check("midrst_ack", LINE_W'(ack_o), '0);
    check("midrst_dout", data_o, '0);
    last_rd = '0;
    acks = 0;
    repeat (12) begin
      tick();
      acks += int'(ack_o);
    end
    check("midrst_no_ack", LINE_W'(acks), '0);
    // Releasing reset with enable high is accepted at the first edge.
    write_i = 1'b0;
    rst_i   = 1'b1;
    do_req(1'b0, 32'h0000_00E0, '0, "rd7", 0);
    check("rd7_kept", data_o, p7);

    // Randomized traffic over the full address space; reads only target known lines.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      if (!w && !ref_vld[line_of(a)]) w = 1'b1;
      do_req(w, a, rand_line(), $sformatf("rnd%0d", i), $urandom_range(0, 2));
      if (w && $urandom_range(0, 1) == 1) do_req(1'b0, a ^ 32'h1F, '0, $sformatf("rnd%0d_rb", i), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
